// File: rtl/bf_io_port.sv
// Byte I/O port: four-phase output handshake with a display dwell, and a debounced
// key-strobed input capture. Optional hex glyph decode of the output byte: HEX_DISPLAY_EN.
module bf_io_port #(
  parameter int DWELL_CYCLES    = 50000000,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Dout,
  input  logic       LdOut,
  output logic       outputDone,
  input  logic [7:0] switches,
  input  logic       key,
  output logic [7:0] DIn,
  output logic       inputDone,
  output logic [7:0] out,
  output logic       outValid,
  output logic [7:0] outCount,
  output logic [6:0] hex0,
  output logic [6:0] hex1
);

  typedef enum logic [1:0] {O_IDLE, O_DWELL, O_ACK} ostate_t;
  typedef enum logic [1:0] {I_IDLE, I_DEB, I_PRESS, I_REL} istate_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  ostate_t          ost_q, ost_d;
  istate_t          ist_q, ist_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d, kcnt_q, kcnt_d;
  logic [7:0]       out_q, out_d, ocnt_q, ocnt_d, din_q, din_d;
  logic             valid_q, valid_d;
  logic [1:0]       ksync_q;
  logic             key_s, dwell_done, deb_done;

  assign key_s      = ksync_q[1];
  // A zero limit means "finish on the first counting cycle".
  assign dwell_done = (DWELL_CYCLES == 0) || (dcnt_q == DWELL_LAST);
  assign deb_done   = (DEBOUNCE_CYCLES == 0) || (kcnt_q == DEB_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ost_q   <= O_IDLE;
      ist_q   <= I_IDLE;
      dcnt_q  <= '0;
      kcnt_q  <= '0;
      out_q   <= '0;
      ocnt_q  <= '0;
      din_q   <= '0;
      valid_q <= 1'b0;
      ksync_q <= '0;
    end else begin
      ost_q   <= ost_d;
      ist_q   <= ist_d;
      dcnt_q  <= dcnt_d;
      kcnt_q  <= kcnt_d;
      out_q   <= out_d;
      ocnt_q  <= ocnt_d;
      din_q   <= din_d;
      valid_q <= valid_d;
      ksync_q <= {ksync_q[0], key};
    end
  end

  // Output side: once loaded, the dwell always runs to completion.
  always_comb begin
    ost_d   = ost_q;
    dcnt_d  = dcnt_q;
    out_d   = out_q;
    ocnt_d  = ocnt_q;
    valid_d = valid_q;
    case (ost_q)
      O_IDLE: if (LdOut) begin
        ost_d   = O_DWELL;
        dcnt_d  = '0;
        out_d   = Dout;
        ocnt_d  = ocnt_q + 8'd1;
        valid_d = 1'b1;
      end
      O_DWELL: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dwell_done) ost_d = O_ACK;
      end
      O_ACK: if (!LdOut) ost_d = O_IDLE;
      default: ost_d = O_IDLE;
    endcase
  end

  // Input side: debounce both press and release; a bounce during release re-enters press.
  always_comb begin
    ist_d  = ist_q;
    kcnt_d = kcnt_q;
    din_d  = din_q;
    case (ist_q)
      I_IDLE: if (key_s) begin
        ist_d  = I_DEB;
        kcnt_d = '0;
      end
      I_DEB: begin
        if (!key_s) ist_d = I_IDLE;
        else begin
          kcnt_d = kcnt_q + 1'b1;
          if (deb_done) begin
            ist_d = I_PRESS;
            din_d = switches;
          end
        end
      end
      I_PRESS: if (!key_s) begin
        ist_d  = I_REL;
        kcnt_d = '0;
      end
      I_REL: begin
        if (key_s) ist_d = I_PRESS;
        else begin
          kcnt_d = kcnt_q + 1'b1;
          if (deb_done) ist_d = I_IDLE;
        end
      end
      default: ist_d = I_IDLE;
    endcase
  end

  assign outputDone = (ost_q == O_ACK);
  assign inputDone  = (ist_q == I_PRESS) || (ist_q == I_REL);
  assign out        = out_q;
  assign outValid   = valid_q;
  assign outCount   = ocnt_q;
  assign DIn        = din_q;

`ifdef HEX_DISPLAY_EN
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  assign hex0 = valid_q ? seg7(out_q[3:0]) : 7'h7F;
  assign hex1 = valid_q ? seg7(out_q[7:4]) : 7'h7F;
`else
  assign hex0 = 7'h7F;
  assign hex1 = 7'h7F;
`endif

endmodule

// File: tb/tb_bf_io_port.sv
// Self-checking bench for bf_io_port: transaction-level model compared every cycle,
// directed handshake/debounce/reset scenarios, then randomized LdOut/key traffic.
module tb_bf_io_port;
  localparam int DW = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] Dout = '0, switches = '0;
  logic       LdOut = 1'b0, key = 1'b0;
  logic       outputDone, inputDone, outValid;
  logic [7:0] DIn, out, outCount;
  logic [6:0] hex0, hex1;

  int checks = 0;
  int failures = 0;

  bf_io_port #(.DWELL_CYCLES(DW), .DEBOUNCE_CYCLES(DB), .CNT_W(26)) dut (
    .clk(clk), .reset(reset), .Dout(Dout), .LdOut(LdOut), .outputDone(outputDone),
    .switches(switches), .key(key), .DIn(DIn), .inputDone(inputDone), .out(out),
    .outValid(outValid), .outCount(outCount), .hex0(hex0), .hex1(hex1)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: modes 0=idle 1=busy(dwell/debounce) 2=done; *_left counts remaining edges.
  int         o_mode = 0, o_left = 0, i_mode = 0, i_left = 0;
  logic [7:0] m_out = '0, m_cnt = '0, m_din = '0;
  logic       m_valid = 1'b0;
  logic [1:0] khist = '0;

  initial forever begin : model
    logic ks;
    @(posedge clk or posedge reset);
    if (reset) begin
      o_mode = 0; o_left = 0; i_mode = 0; i_left = 0;
      m_out = '0; m_cnt = '0; m_din = '0; m_valid = 1'b0; khist = '0;
    end else begin
      ks = khist[1];
      khist = {khist[0], key};
      case (o_mode)
        0: if (LdOut) begin
          o_mode = 1; o_left = DW; m_out = Dout; m_valid = 1'b1; m_cnt = m_cnt + 8'd1;
        end
        1: if (o_left <= 1) o_mode = 2; else o_left--;
        default: if (!LdOut) o_mode = 0;
      endcase
      // i_mode: 0 idle, 1 debouncing press, 2 pressed, 3 debouncing release
      case (i_mode)
        0: if (ks) begin i_mode = 1; i_left = DB; end
        1: if (!ks) i_mode = 0;
           else if (i_left <= 1) begin i_mode = 2; m_din = switches; end
           else i_left--;
        2: if (!ks) begin i_mode = 3; i_left = DB; end
        default: if (ks) i_mode = 2;
                 else if (i_left <= 1) i_mode = 0;
                 else i_left--;
      endcase
    end
  end

  function automatic logic [6:0] m_hex(input logic [3:0] n);
`ifdef HEX_DISPLAY_EN
    m_hex = m_valid ? glyph[n] : 7'h7F;
`else
    m_hex = 7'h7F;
`endif
  endfunction

  initial forever begin
    @(negedge clk);
    chk("outputDone", outputDone, o_mode == 2);
    chk("inputDone", inputDone, i_mode >= 2);
    chk("out", out, m_out);
    chk("outValid", outValid, m_valid);
    chk("outCount", outCount, m_cnt);
    chk("DIn", DIn, m_din);
    chk("hex0", hex0, m_hex(m_out[3:0]));
    chk("hex1", hex1, m_hex(m_out[7:4]));
  end

  task automatic handshake(input logic [7:0] d);
    int n;
    @(negedge clk);
    Dout = d; LdOut = 1'b1; n = 0;
    while (!outputDone && n < 50) begin @(negedge clk); n++; end
    if (!outputDone) chk("hs_ack_timeout", outputDone, 1);
    LdOut = 1'b0; n = 0;
    while (outputDone && n < 50) begin @(negedge clk); n++; end
    if (outputDone) chk("hs_release_timeout", outputDone, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_out"}, out, 8'h00);
    chk({tag, "_outValid"}, outValid, 1'b0);
    chk({tag, "_outCount"}, outCount, 8'h00);
    chk({tag, "_DIn"}, DIn, 8'h00);
    chk({tag, "_outputDone"}, outputDone, 1'b0);
    chk({tag, "_inputDone"}, inputDone, 1'b0);
  endtask

  initial begin
    int n;
    logic seen;
    logic [7:0] last;
    #2 reset = 1'b1;
    #1 all_zero("rst");
    chk("rst_hex0", hex0, 7'h7F);
    @(negedge clk); reset = 1'b0;

    // Output latency: the load edge plus DW dwell edges.
    @(negedge clk); Dout = 8'h41; LdOut = 1'b1;
    @(posedge clk); #1 n = 1;
    chk("load_out", out, 8'h41);
    chk("load_count", outCount, 8'd1);
    while (!outputDone && n < 20) begin @(posedge clk); #1 n++; end
    chk("ack_edges", n, 5);
    @(negedge clk); LdOut = 1'b0;
    @(posedge clk); #1 chk("ack_fall", outputDone, 1'b0);

    // Input latency: 2 sync edges, 1 edge into debounce, 3 debounce edges.
    @(negedge clk); switches = 8'h5A; key = 1'b1; n = 0;
    while (!inputDone && n < 20) begin @(posedge clk); #1 n++; end
    chk("press_edges", n, 6);
    chk("press_din", DIn, 8'h5A);
    repeat (4) @(posedge clk);
    @(negedge clk); key = 1'b0; switches = 8'hA5; n = 0;
    while (inputDone && n < 20) begin @(posedge clk); #1 n++; end
    chk("release_edges", n, 6);
    chk("din_held", DIn, 8'h5A);

    // Short key pulse must be rejected by the debouncer.
    @(negedge clk); key = 1'b1; switches = 8'hFF;
    @(negedge clk); @(negedge clk); key = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1 seen |= inputDone; end
    chk("glitch_done", seen, 1'b0);
    chk("glitch_din", DIn, 8'h5A);

    handshake(8'h3C);
`ifdef HEX_DISPLAY_EN
    chk("hex0_3C", hex0, 7'b1000110);
    chk("hex1_3C", hex1, 7'b0110000);
`else
    chk("hex0_3C", hex0, 7'h7F);
    chk("hex1_3C", hex1, 7'h7F);
`endif

    // Count wrap after 256 handshakes from reset.
    do_reset();
    last = '0;
    for (int i = 0; i < 256; i++) begin
      last = 8'($urandom);
      handshake(last);
    end
    chk("wrap_count", outCount, 8'h00);
    chk("wrap_out", out, last);

    // Asynchronous reset with output dwelling and input pressed.
    do_reset();
    @(negedge clk); key = 1'b1; switches = 8'h33;
    repeat (4) @(posedge clk);
    @(negedge clk); LdOut = 1'b1; Dout = 8'h77;
    repeat (2) @(posedge clk);
    #2 chk("pre_dwell", outputDone, 1'b0);
    chk("pre_press", inputDone, 1'b1);
    chk("pre_out", out, 8'h77);
    key = 1'b0; reset = 1'b1;
    #1 all_zero("async");
    @(negedge clk); reset = 1'b0; n = 0;
    while (!outputDone && n < 20) begin @(posedge clk); #1 n++; end
    chk("reload_edges", n, 5);
    chk("reload_count", outCount, 8'd1);
    @(negedge clk); LdOut = 1'b0;

    // Random traffic, including LdOut drops mid-dwell and key bounces.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      Dout = 8'($urandom);
      switches = 8'($urandom);
      if ($urandom_range(0, 9) == 0) LdOut = ~LdOut;
      if ($urandom_range(0, 5) == 0) key = ~key;
    end
    @(negedge clk); LdOut = 1'b0; key = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
